lcd_write_scheduler: RTL and testbench
======================================

Name: lcd_write_scheduler

Overview:
- Shares one HD44780-style 8-bit LCD bus between two requesters, e.g. a static-text writer and a live-value updater.
- Each requester offers one byte at a time (command or character) through a valid/ready handshake. The block grants access round-robin.
- For each granted byte it drives rs/rw/en/data with programmable setup, enable-pulse, hold and execution-wait times.
- It sits between the display content generators and the LCD pins and replaces free-running enable toggling.

Parameters:
DATA_BITS, 8, LCD data bus width
T_POWERUP, 2000000, cycles to wait after reset before the first grant (40 ms at 50 MHz)
T_SETUP, 2, cycles rs/data are stable with en low before the pulse
T_EN, 25, cycles en is held high
T_HOLD, 2, cycles rs/data are held with en low after the pulse
T_SHORT, 2500, execution wait for ordinary commands and characters
T_LONG, 100000, execution wait for clear/home commands (rs=0 and data is 0x01, 0x02 or 0x03)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has a byte
req0_rs  in  1  0 = command, 1 = character
req0_data  in  DATA_BITS  byte from requester 0
req0_ready  out  1  requester 0 byte accepted this cycle
req1_valid  in  1  requester 1 has a byte
req1_rs  in  1  0 = command, 1 = character
req1_data  in  DATA_BITS  byte from requester 1
req1_ready  out  1  requester 1 byte accepted this cycle
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; tied 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_data  out  DATA_BITS  LCD data bus
busy  out  1  high in every state except IDLE
grant_id  out  1  requester of the last accepted byte

Behaviour:
- Reset (synchronous, dominant at any time, including mid-pulse):
  - state = POWERUP, counter = 0.
  - lcd_en = 0, lcd_rs = 0, lcd_rw = 0, lcd_data = 0, req*_ready = 0.
  - grant_id = 0, busy = 1, last-grant pointer = 1, so requester 0 wins the first tie.
- States: POWERUP -> IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
- POWERUP: counts T_POWERUP cycles with outputs at their reset values, then goes to IDLE.
- IDLE, ready generation (combinational):
  - If exactly one valid is high, that requester's ready = 1.
  - If both are high, ready goes to the requester other than the last-grant pointer.
  - At most one ready is high, and only in IDLE.
- IDLE, transfer (on the edge where valid && ready):
  - lcd_rs and lcd_data register the winner's rs/data.
  - grant_id and the pointer take the winner; state -> SETUP; counter cleared.
  - Ready never depends on a requester holding valid for more than the accepting cycle.
- SETUP (T_SETUP cycles): en = 0.
- PULSE (T_EN cycles): en = 1.
- HOLD (T_HOLD cycles): en = 0.
- Across SETUP, PULSE and HOLD, lcd_rs and lcd_data stay constant.
- WAIT (T_SHORT or T_LONG cycles): en = 0.
  - The long/short choice is decoded at transfer time from the latched byte: rs = 0 and data[7:2] = 0 and data != 0 selects T_LONG.
  - lcd_data and lcd_rs keep their last value.
- Byte period: transfer edge to the next possible accept = T_SETUP + T_EN + T_HOLD + T_WAIT + 1 cycles.
- Counter: one shared down-counter (or up-counter compared to the phase limit), width $clog2 of the largest parameter + 1. No wrap-around occurs inside a phase.
- A requester dropping valid without a handshake is legal; no byte is consumed.
- A valid held high during busy waits, and is never lost or duplicated.
- Sustained valid on both requesters strictly alternates grants 0,1,0,1…
- Invariants: lcd_rw is always 0; en is never high outside PULSE.

Test Plan:
Use bench parameters T_POWERUP=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_SHORT=8, T_LONG=20.
1. Reset, then req0_valid=1, rs=1, data=0x41 held from cycle 0 -> no ready during cycles 0-9. req0_ready=1 at cycle 10. lcd_rs=1, lcd_data=0x41 from cycle 11. lcd_en high exactly cycles 13-16. Next ready at cycle 27 (period 17).
2. Both valid continuously with distinct bytes -> grants 0,1,0,1. grant_id toggles per accept. Each byte appears on lcd_data exactly once, in order per requester.
3. req1 sends rs=0, data=0x01 -> en pulse of 4 cycles, then WAIT of 20 cycles. Next accept 29 cycles after the transfer. rs=0, 0x38 gives 17 cycles; rs=1, 0x01 gives 17 cycles.
4. Assert reset during PULSE -> next cycle lcd_en=0, lcd_data=0, busy=1, state POWERUP. The pending byte is not re-driven, and the first grant after release goes to requester 0.
5. req0 pulses valid for one cycle during WAIT, then drops it -> no ready, no transfer, and the bus stays idle after WAIT.
6. Whole run -> assert lcd_rw=0 always, at most one ready per cycle, and lcd_data/lcd_rs stable whenever lcd_en=1.

Source files
------------

// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - round-robin scheduler driving an HD44780-style LCD write bus
// Purpose: arbitrates two byte requesters onto one LCD bus and times each write
//   (setup, enable pulse, hold, execution wait) after a power-up delay.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req0_valid/rs/data, req0_ready byte handshake from requester 0
//   req1_valid/rs/data, req1_ready byte handshake from requester 1
//   lcd_rs, lcd_rw, lcd_en, lcd_data   LCD pins (rw tied low)
//   busy                           low only while waiting for a new byte
//   grant_id                       requester of the last accepted byte
module lcd_write_scheduler #(
  parameter int DATA_BITS = 8,
  parameter int T_POWERUP = 2000000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 25,
  parameter int T_HOLD    = 2,
  parameter int T_SHORT   = 2500,
  parameter int T_LONG    = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req0_rs,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic                 req1_rs,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_en,
  output logic [DATA_BITS-1:0] lcd_data,
  output logic                 busy,
  output logic                 grant_id
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                              max2(T_SHORT, T_LONG));
  localparam int CW = $clog2(T_MAX) + 1;

  // Terminal counts: the counter runs 0..limit-1 inside each timed phase.
  localparam logic [CW-1:0] LIM_POWERUP = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] LIM_SETUP   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LIM_EN      = CW'(T_EN - 1);
  localparam logic [CW-1:0] LIM_HOLD    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LIM_SHORT   = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LIM_LONG    = CW'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t                 state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic                   last_grant;
  logic                   long_wait;
  logic                   take0, take1;
  logic                   sel_rs;
  logic [DATA_BITS-1:0]   sel_data;
  logic                   sel_long;

  assign lcd_rw = 1'b0;

  // Byte presented by the winner; only meaningful when take0 or take1 is set.
  assign sel_rs   = take1 ? req1_rs : req0_rs;
  assign sel_data = take1 ? req1_data : req0_data;
  // Clear display / return home (0x01..0x03 as a command) need the long wait.
  assign sel_long = !sel_rs && (sel_data[DATA_BITS-1:2] == '0) && (sel_data != '0);

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take0      = 1'b0;
    take1      = 1'b0;
    lcd_en     = 1'b0;
    busy       = 1'b1;
    state_next = state;
    cnt_next   = cnt + CW'(1);
    case (state)
      S_POWERUP: begin
        if (cnt == LIM_POWERUP) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      S_IDLE: begin
        busy     = 1'b0;
        cnt_next = '0;
        // On a tie the requester that was not granted last time wins.
        req0_ready = req0_valid && (!req1_valid || last_grant);
        req1_ready = req1_valid && (!req0_valid || !last_grant);
        take0      = req0_ready;
        take1      = req1_ready;
        if (take0 || take1) state_next = S_SETUP;
      end
      S_SETUP: begin
        if (cnt == LIM_SETUP) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end
      end
      S_PULSE: begin
        lcd_en = 1'b1;
        if (cnt == LIM_EN) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == LIM_HOLD) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (cnt == (long_wait ? LIM_LONG : LIM_SHORT)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_POWERUP;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_POWERUP;
      cnt        <= '0;
      lcd_rs     <= 1'b0;
      lcd_data   <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      long_wait  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (take0 || take1) begin
        lcd_rs     <= sel_rs;
        lcd_data   <= sel_data;
        grant_id   <= take1;
        last_grant <= take1;
        long_wait  <= sel_long;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// tb/tb_lcd_write_scheduler.sv - self-checking bench for lcd_write_scheduler
// Purpose: drives both requesters from byte queues and compares the LCD bus
//   every cycle against a timestamp-based model of the write schedule.
module tb_lcd_write_scheduler;

  localparam int T_POWERUP = 10;
  localparam int T_SETUP   = 2;
  localparam int T_EN      = 4;
  localparam int T_HOLD    = 2;
  localparam int T_SHORT   = 8;
  localparam int T_LONG    = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0, req1_rs = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       lcd_rs, lcd_rw, lcd_en, busy, grant_id;
  logic [7:0] lcd_data;

  lcd_write_scheduler #(
    .DATA_BITS(8), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
    .T_HOLD(T_HOLD), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Stimulus state (written by the main process only).
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         mode0 = 0, mode1 = 0;   // 0 hold valid, 1 random valid, 2 manual
  logic       man_v0 = 1'b0;
  logic [8:0] man_b0 = 9'h0;
  int         lit_mode = 0;
  int         end_code = 0, end_req = 0;

  // Model / monitor state (written by the compare process only).
  int   cyc = 0;
  int   m_idle_at = T_POWERUP;
  int   m_xt = 0;
  bit   m_have = 0;
  logic m_rs = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit   m_ptr = 1, m_gid = 0;
  int   n_acc = 0, n_rise = 0;
  int   acc_cyc[0:63];
  bit   acc_who[0:63];
  bit   acc0 = 0, acc1 = 0;
  bit   prev_rst = 0;
  logic prev_en = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int   end_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, want);
    end
  endtask

  function automatic int period_of(input logic rs, input logic [7:0] d);
    bit is_long;
    is_long = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    return T_SETUP + T_EN + T_HOLD + (is_long ? T_LONG : T_SHORT) + 1;
  endfunction

  always @(negedge clk) begin
    bit idle, win, e_r0, e_r1, e_en;
    if (reset) begin
      if (prev_rst) begin
        check("rst_en", lcd_en, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_data", lcd_data, 0);
        check("rst_busy", busy, 1);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_grant", grant_id, 0);
        check("rst_rw", lcd_rw, 0);
      end
      prev_rst = 1; m_idle_at = T_POWERUP; m_have = 0; m_rs = 1'b0; m_data = 8'h00;
      m_ptr = 1; m_gid = 0; cyc = 0; n_acc = 0; n_rise = 0; prev_en = 1'b0;
      acc0 = 0; acc1 = 0;
    end else begin
      prev_rst = 0;
      idle = (cyc >= m_idle_at);
      win = 0; e_r0 = 0; e_r1 = 0;
      if (idle && (req0_valid || req1_valid)) begin
        if (req0_valid && req1_valid) win = !m_ptr;
        else win = req1_valid;
        e_r0 = (win == 0);
        e_r1 = (win == 1);
      end
      e_en = m_have && (cyc > m_xt + T_SETUP) && (cyc <= m_xt + T_SETUP + T_EN);
      check("ready0", req0_ready, e_r0);
      check("ready1", req1_ready, e_r1);
      check("busy", busy, !idle);
      check("lcd_en", lcd_en, e_en);
      check("lcd_rs", lcd_rs, m_rs);
      check("lcd_data", lcd_data, m_data);
      check("grant_id", grant_id, m_gid);
      check("lcd_rw", lcd_rw, 0);
      check("one_ready", req0_ready & req1_ready, 0);
      if (lcd_en && prev_en) check("en_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
      if (lit_mode == 1) begin
        case (cyc)
          9:  check("p1_ready_c9", req0_ready, 0);
          10: check("p1_ready_c10", req0_ready, 1);
          11: check("p1_bus_c11", {lcd_rs, lcd_data}, 9'h141);
          12: check("p1_en_c12", lcd_en, 0);
          13: check("p1_en_c13", lcd_en, 1);
          16: check("p1_en_c16", lcd_en, 1);
          17: check("p1_en_c17", lcd_en, 0);
          26: check("p1_ready_c26", req0_ready, 0);
          27: check("p1_ready_c27", req0_ready, 1);
          default: ;
        endcase
      end
      if (lcd_en && !prev_en) n_rise++;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (e_r0 || e_r1) begin
        m_rs   = win ? req1_rs : req0_rs;
        m_data = win ? req1_data : req0_data;
        m_xt = cyc; m_have = 1; m_gid = win; m_ptr = win;
        m_idle_at = cyc + period_of(m_rs, m_data);
        if (n_acc < 64) begin
          acc_cyc[n_acc] = cyc;
          acc_who[n_acc] = win;
        end
        n_acc++;
      end
      if (end_req != end_done) begin
        check("drained", q0.size() + q1.size(), 0);
        check("idle_at_end", busy, 0);
        check("rise_vs_accept", n_rise, n_acc);
        case (end_code)
          1: check("p1_accepts", n_acc, 2);
          2: begin
            check("p2_accepts", n_acc, 8);
            for (int i = 0; i < 8; i++) check("p2_alternate", acc_who[i], i % 2);
          end
          3: begin
            check("p3_gap_long", acc_cyc[1] - acc_cyc[0], 29);
            check("p3_gap_cmd", acc_cyc[2] - acc_cyc[1], 17);
            check("p3_gap_char", acc_cyc[3] - acc_cyc[2], 17);
          end
          4: begin
            check("p4_first_win", acc_who[0], 0);
            check("p4_second_win", acc_who[1], 1);
          end
          5: check("p5_accepts", n_acc, 1);
          default: ;
        endcase
        end_done = end_req;
      end
      prev_en = lcd_en; prev_rs = lcd_rs; prev_data = lcd_data;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (mode0 == 2) begin
      req0_valid = man_v0;
      {req0_rs, req0_data} = man_b0;
    end else begin
      req0_valid = (q0.size() > 0) && (mode0 == 0 || $urandom_range(0, 2) != 0);
      {req0_rs, req0_data} = (q0.size() > 0) ? q0[0] : 9'h0;
    end
    req1_valid = (q1.size() > 0) && (mode1 == 0 || $urandom_range(0, 2) != 0);
    {req1_rs, req1_data} = (q1.size() > 0) ? q1[0] : 9'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy) && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic phase_end(input int code);
    end_code = code;
    end_req++;
    step();
    step();
  endtask

  initial begin
    logic [8:0] b;
    int n;

    // Single requester, literal timing of the first two bytes.
    lit_mode = 1;
    q0.push_back(9'h141);
    q0.push_back(9'h142);
    do_reset();
    run_until_done(500);
    lit_mode = 0;
    phase_end(1);

    // Sustained valid on both requesters alternates grants.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(9'h110 + 9'(i));
      q1.push_back(9'h120 + 9'(i));
    end
    do_reset();
    run_until_done(1000);
    phase_end(2);

    // Long versus short execution waits.
    q1.push_back(9'h001);
    q1.push_back(9'h038);
    q1.push_back(9'h101);
    q1.push_back(9'h000);
    do_reset();
    run_until_done(1000);
    phase_end(3);

    // Reset in the middle of the enable pulse, then a tie after release.
    q0.push_back(9'h155);
    do_reset();
    n = 0;
    while (!lcd_en && n < 200) begin
      step();
      n++;
    end
    step();
    q0.delete();
    q1.delete();
    do_reset();
    q0.push_back(9'h150);
    q0.push_back(9'h151);
    q1.push_back(9'h160);
    q1.push_back(9'h161);
    run_until_done(1000);
    phase_end(4);

    // One-cycle valid blip during the execution wait is ignored.
    mode0 = 2;
    man_v0 = 1'b0;
    man_b0 = 9'h177;
    q1.push_back(9'h133);
    do_reset();
    n = 0;
    while (!lcd_en && n < 200) begin
      step();
      n++;
    end
    repeat (8) step();
    man_v0 = 1'b1;
    step();
    man_v0 = 1'b0;
    step();
    run_until_done(200);
    repeat (20) step();
    phase_end(5);
    mode0 = 0;

    // Randomized traffic with random valid gaps on both requesters.
    mode0 = 1;
    mode1 = 1;
    for (int i = 0; i < 30; i++) begin
      b[8] = 1'($urandom_range(0, 1));
      b[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      q0.push_back(b);
      b[8] = 1'($urandom_range(0, 1));
      b[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      q1.push_back(b);
    end
    do_reset();
    run_until_done(6000);
    phase_end(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
